// File: rtl/vga_timing_controller.sv
// vga_timing_controller
//   Free-running 640x480@60 Hz raster timing generator driven by the 25 MHz
//   pixel clock. Every output is a register loaded from the next-state
//   counter values, so all outputs describe the same pixel in the same cycle.
//
//   Ports
//     vga_clk      in   pixel clock, rising-edge active
//     reset_n      in   asynchronous active-low reset
//     hs, vs       out  horizontal / vertical sync, active low
//     blank        out  1 = visible pixel
//     sync         out  composite sync, constant 0
//     DrawX/DrawY  out  current pixel column / line (10 bits)
//     line_start   out  1-cycle pulse while DrawX==0
//     frame_start  out  1-cycle pulse while DrawX==0 and DrawY==0
//     frame_count  out  8-bit frame index, bumps with frame_start, wraps
`timescale 1ns/1ps
module vga_timing_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  always_comb begin
    hc_d = (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST)
      vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;

    // Decode from the next-state counters so the registered flags line up
    // with the registered coordinates (zero skew between outputs).
    hs_d          = !((hc_d >= HS_START) && (hc_d < HS_END));
    vs_d          = !((vc_d >= VS_START) && (vc_d < VS_END));
    blank_d       = (hc_d < H_ACT) && (vc_d < V_ACT);
    line_start_d  = (hc_d == 10'd0);
    frame_start_d = (hc_d == 10'd0) && (vc_d == 10'd0);
    frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
  end

  // Reset parks the counters on the last pixel of the frame so the first
  // edge after release lands on (0,0) with frame_start and frame_count=0.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= H_LAST;
      vc_q          <= V_LAST;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'hFF;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign sync        = 1'b0;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller
//   Two instances share one pixel clock: dut_a uses the real 640x480 timing
//   for reset, first-line and async-reset checks; dut_b uses a shrunken raster
//   (16x12 total) so hundreds of whole frames fit in a short run and every
//   cycle can be scored against a position-based reference.
`timescale 1ns/1ps
module tb_vga_timing_controller;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sync;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  typedef struct {
    int   n;
    out_t exp;
  } vec_t;

  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 6, SVF = 2, SVS = 2, SVB = 2;
  localparam int SHT = SHA + SHF + SHS + SHB;   // 16
  localparam int SVT = SVA + SVF + SVS + SVB;   // 12
  localparam int SFR = SHT * SVT;               // 192 cycles per frame

  logic gclk = 1'b0;
  always #20 gclk = ~gclk;

  logic rst_a, rst_b;
  logic       hs_a, vs_a, blank_a, sync_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [7:0] fc_a;
  logic       hs_b, vs_b, blank_b, sync_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic [7:0] fc_b;

  vga_timing_controller dut_a (
    .vga_clk(gclk), .reset_n(rst_a), .hs(hs_a), .vs(vs_a), .blank(blank_a),
    .sync(sync_a), .DrawX(x_a), .DrawY(y_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_controller #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_b (
    .vga_clk(gclk), .reset_n(rst_b), .hs(hs_b), .vs(vs_b), .blank(blank_b),
    .sync(sync_b), .DrawX(x_b), .DrawY(y_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_count(fc_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic out_t mk(int x, int y, bit hs, bit vs, bit blank,
                              bit ls, bit fs, int fc);
    out_t o;
    o.x = 10'(x); o.y = 10'(y); o.hs = hs; o.vs = vs; o.blank = blank;
    o.sync = 1'b0; o.ls = ls; o.fs = fs; o.fc = 8'(fc);
    return o;
  endfunction

  // Reference derived purely from the cycle index since reset release.
  function automatic out_t model(int n, int ha, int hf, int hsy, int hb,
                                 int va, int vf, int vsy, int vb);
    int ht, vt, x, y, f;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    x  = n % ht;
    y  = (n / ht) % vt;
    f  = n / (ht * vt);
    return mk(x, y, !(x >= ha + hf && x < ha + hf + hsy),
              !(y >= va + vf && y < va + vf + vsy),
              (x < ha) && (y < va), x == 0, (x == 0) && (y == 0), f % 256);
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("x=%0d y=%0d hs=%b vs=%b blank=%b sync=%b ls=%b fs=%b fc=%0d",
                     o.x, o.y, o.hs, o.vs, o.blank, o.sync, o.ls, o.fs, o.fc);
  endfunction

  function automatic out_t act_a();
    return '{x_a, y_a, hs_a, vs_a, blank_a, sync_a, ls_a, fs_a, fc_a};
  endfunction

  function automatic out_t act_b();
    return '{x_b, y_b, hs_b, vs_b, blank_b, sync_b, ls_b, fs_b, fc_b};
  endfunction

  task automatic chk(string name, out_t act, out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  vec_t tbl[12];
  out_t sb_q[$];

  initial begin
    out_t rst_full, rst_small, e;
    int   ti, hs_low, fs_seen, vs_low, vis_cnt;
    bit   seen[SHT][SVT];

    // DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
    tbl[0]  = '{0,    mk(0,   0, 1, 1, 1, 1, 1, 0)};
    tbl[1]  = '{1,    mk(1,   0, 1, 1, 1, 0, 0, 0)};
    tbl[2]  = '{639,  mk(639, 0, 1, 1, 1, 0, 0, 0)};
    tbl[3]  = '{640,  mk(640, 0, 1, 1, 0, 0, 0, 0)};
    tbl[4]  = '{655,  mk(655, 0, 1, 1, 0, 0, 0, 0)};
    tbl[5]  = '{656,  mk(656, 0, 0, 1, 0, 0, 0, 0)};
    tbl[6]  = '{751,  mk(751, 0, 0, 1, 0, 0, 0, 0)};
    tbl[7]  = '{752,  mk(752, 0, 1, 1, 0, 0, 0, 0)};
    tbl[8]  = '{799,  mk(799, 0, 1, 1, 0, 0, 0, 0)};
    tbl[9]  = '{800,  mk(0,   1, 1, 1, 1, 1, 0, 0)};
    tbl[10] = '{1099, mk(299, 1, 1, 1, 1, 0, 0, 0)};
    tbl[11] = '{1100, mk(300, 1, 1, 1, 1, 0, 0, 0)};

    rst_full  = mk(799, 524, 1, 1, 0, 0, 0, 255);
    rst_small = mk(SHT - 1, SVT - 1, 1, 1, 0, 0, 0, 255);

    // ---- full-size instance: reset, first line, async reset mid-line ----
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(posedge gclk);
    @(negedge gclk);
    chk("reset_full", act_a(), rst_full);
    chk("reset_small", act_b(), rst_small);
    rst_a = 1'b1;

    ti = 0;
    hs_low = 0;
    for (int n = 0; n <= 1100; n++) begin
      @(negedge gclk);
      if (n < 800 && hs_a == 1'b0) hs_low++;
      if (ti < 12 && tbl[ti].n == n) begin
        chk($sformatf("vec_n%0d", n), act_a(), tbl[ti].exp);
        ti++;
      end
    end
    chk_int("hs_low_cycles_line0", hs_low, 96);

    // Assert reset between edges: outputs must fall back without a clock.
    rst_a = 1'b0;
    #1;
    chk("async_reset_immediate", act_a(), rst_full);
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    chk("async_reset_held", act_a(), rst_full);
    rst_a = 1'b1;
    @(negedge gclk);
    chk("restart_origin", act_a(), mk(0, 0, 1, 1, 1, 1, 1, 0));
    @(negedge gclk);
    chk("restart_next", act_a(), mk(1, 0, 1, 1, 1, 0, 0, 0));

    // ---- shrunken instance: 257 full frames, every cycle scored ----
    @(negedge gclk);
    chk("reset_small_held", act_b(), rst_small);
    rst_b = 1'b1;
    fs_seen = 0;
    vs_low  = 0;
    vis_cnt = 0;
    for (int i = 0; i < SHT; i++)
      for (int j = 0; j < SVT; j++)
        seen[i][j] = 1'b0;

    for (int n = 0; n <= 257 * SFR; n++) begin
      @(posedge gclk);
      sb_q.push_back(model(n, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
      @(negedge gclk);
      e = sb_q.pop_front();
      chk($sformatf("small_n%0d", n), act_b(), e);
      if (fs_b) begin
        chk_int($sformatf("fc_at_frame%0d", fs_seen), int'(fc_b), fs_seen % 256);
        fs_seen++;
      end
      if (!vs_b) vs_low++;
      if (n < SFR && blank_b && x_b < 10'(SHT) && y_b < 10'(SVT)) begin
        if (!seen[x_b][y_b]) vis_cnt++;
        seen[x_b][y_b] = 1'b1;
      end
    end
    chk_int("frame_starts", fs_seen, 258);
    chk_int("vs_low_cycles", vs_low, 257 * SVS * SHT);
    chk_int("visible_pixels", vis_cnt, SHA * SVA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
